fwrisc_fetch_pf: RTL and testbench

Parametrised prefetching fetch unit for the fwrisc core, sitting between the instruction bus and decode. It runs ahead of decode on sequential addresses and buffers up to `DEPTH` aligned 32-bit words. It assembles aligned and unaligned 32-bit or 16-bit (compressed) instructions from the buffered halfwords. A single-cycle `flush` redirects it to a new PC and discards all stale state.

---
 rtl/fwrisc_fetch_pf.sv | 128 ++++++++++++
 tb/tb_fwrisc_fetch_pf.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_fetch_pf.sv
// Prefetching instruction fetch unit: runs ahead of decode on sequential word
// addresses and assembles 16/32-bit instructions from a small circular word buffer.
module fwrisc_fetch_pf #(
    parameter bit          ENABLE_COMPRESSED = 1'b1,
    parameter int          DEPTH             = 4,
    parameter logic [31:0] RESET_PC          = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [31:0] iaddr,
    output logic        ivalid,
    input  logic        iready,
    input  logic [31:0] idata,
    output logic        fetch_valid,
    input  logic        decode_ready,
    output logic [31:0] instr,
    output logic        instr_c,
    output logic [31:0] instr_pc
);

    localparam int          CW       = $clog2(DEPTH + 1);
    localparam int          PW       = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    // Without compressed support every instruction is word aligned.
    localparam logic [31:0] PC_MASK  = ENABLE_COMPRESSED ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

    logic [31:0]   buf_q [DEPTH];
    logic [31:0]   buf_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   faddr_q, faddr_d;
    logic [31:0]   pc_q, pc_d;

    logic [31:0] head;
    logic [31:0] next_w;
    logic        hp;
    logic [15:0] half;
    logic        is_c;
    logic        asm_valid;
    logic        push;
    logic        xfer;
    logic        pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Instruction assembly looks only at buffered words, never at idata.
    always_comb begin
        head      = buf_q[rd_ptr_q];
        next_w    = buf_q[ptr_inc(rd_ptr_q)];
        hp        = ENABLE_COMPRESSED ? pc_q[1] : 1'b0;
        half      = hp ? head[31:16] : head[15:0];
        is_c      = ENABLE_COMPRESSED && (half[1:0] != 2'b11);
        asm_valid = (!is_c && hp) ? (count_q >= CW'(2)) : (count_q != '0);

        ivalid      = !reset && !flush && (count_q < DEPTH_C);
        iaddr       = faddr_q;
        fetch_valid = asm_valid && !flush && !reset;
        instr_pc    = pc_q;
        instr_c     = fetch_valid && is_c;
        instr       = '0;
        if (fetch_valid) begin
            if (is_c)
                instr = {16'h0000, half};
            else if (hp)
                instr = {next_w[15:0], half};
            else
                instr = head;
        end

        push = ivalid && iready;
        xfer = fetch_valid && decode_ready;
        // A compressed instruction in the low half leaves its word in place.
        pop  = xfer && !(is_c && !hp);
    end

    always_comb begin
        buf_d    = buf_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        faddr_d  = faddr_q;
        pc_d     = pc_q;

        if (reset) begin
            for (int i = 0; i < DEPTH; i++) buf_d[i] = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = RESET_PC & PC_MASK;
            faddr_d  = RESET_PC & 32'hFFFF_FFFC;
        end else if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = flush_pc & PC_MASK;
            faddr_d  = flush_pc & 32'hFFFF_FFFC;
        end else begin
            if (push) begin
                buf_d[wr_ptr_q] = idata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
                faddr_d         = faddr_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (xfer) begin
                pc_d = pc_q + (is_c ? 32'd2 : 32'd4);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        buf_q    <= buf_d;
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
        faddr_q  <= faddr_d;
        pc_q     <= pc_d;
    end

endmodule

// File: tb/tb_fwrisc_fetch_pf.sv
// Bench for fwrisc_fetch_pf: a compressed-enabled DEPTH=4 instance and a 32-bit-only
// DEPTH=3 instance run the same stimulus against a pc/fetch-address reference model.
module tb_fwrisc_fetch_pf;

    localparam logic [31:0] RPC0 = 32'h8000_0000;
    localparam logic [31:0] RPC1 = 32'h8000_0003;
    localparam int          D0   = 4;
    localparam int          D1   = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        c;
    } xfer_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] flush_pc;
    logic        iready;
    logic        decode_ready;

    logic [31:0] iaddr0, idata0, instr0, instr_pc0;
    logic        ivalid0, fetch_valid0, instr_c0;
    logic [31:0] iaddr1, idata1, instr1, instr_pc1;
    logic        ivalid1, fetch_valid1, instr_c1;

    logic [31:0] mem [256];
    logic [31:0] m_pc [2];
    logic [31:0] m_fa [2];
    logic        last_fv [2];
    logic        last_iv [2];
    xfer_t       log0 [$];
    xfer_t       log1 [$];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    assign idata0 = mem[iaddr0[9:2]];
    assign idata1 = mem[iaddr1[9:2]];

    fwrisc_fetch_pf #(.ENABLE_COMPRESSED(1'b1), .DEPTH(D0), .RESET_PC(RPC0)) u_dut0 (
        .clock(clock), .reset(reset), .flush(flush), .flush_pc(flush_pc),
        .iaddr(iaddr0), .ivalid(ivalid0), .iready(iready), .idata(idata0),
        .fetch_valid(fetch_valid0), .decode_ready(decode_ready),
        .instr(instr0), .instr_c(instr_c0), .instr_pc(instr_pc0)
    );

    fwrisc_fetch_pf #(.ENABLE_COMPRESSED(1'b0), .DEPTH(D1), .RESET_PC(RPC1)) u_dut1 (
        .clock(clock), .reset(reset), .flush(flush), .flush_pc(flush_pc),
        .iaddr(iaddr1), .ivalid(ivalid1), .iready(iready), .idata(idata1),
        .fetch_valid(fetch_valid1), .decode_ready(decode_ready),
        .instr(instr1), .instr_c(instr_c1), .instr_pc(instr_pc1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Buffered words = words fetched beyond the word holding pc; instruction comes from memory at pc.
    function automatic void predict(input int i, input logic rst, input logic fl,
                                    output logic iv, output logic fv,
                                    output logic [31:0] ins, output logic c);
        logic [31:0] pc;
        logic [31:0] occ;
        logic [31:0] w0, w1;
        logic [15:0] h;
        logic [7:0]  wi;
        int          depth;
        int          need;
        bit          ec;
        pc    = m_pc[i];
        ec    = (i == 0);
        depth = (i == 0) ? D0 : D1;
        occ   = (m_fa[i] - (pc & ~32'h3)) >> 2;
        wi    = pc[9:2];
        w0    = mem[wi];
        wi    = wi + 8'd1;
        w1    = mem[wi];
        h     = pc[1] ? w0[31:16] : w0[15:0];
        c     = ec && (h[1:0] != 2'b11);
        need  = (!c && pc[1]) ? 2 : 1;
        iv    = !rst && !fl && (occ < 32'(depth));
        fv    = !rst && !fl && (occ >= 32'(need));
        if (c)
            ins = {16'h0000, h};
        else if (pc[1])
            ins = {w1[15:0], h};
        else
            ins = w0;
        if (!fv) begin
            ins = 32'h0;
            c   = 1'b0;
        end
    endfunction

    task automatic step(input logic rst, input logic fl, input logic [31:0] fpc,
                        input logic ir, input logic dr);
        logic        iv, fv, c;
        logic [31:0] ins;
        logic [31:0] o_ia, o_ins, o_pc;
        logic        o_iv, o_fv, o_c;
        logic [31:0] np [2];
        logic [31:0] nf [2];
        string       sfx;
        @(negedge clock);
        reset        = rst;
        flush        = fl;
        flush_pc     = fpc;
        iready       = ir;
        decode_ready = dr;
        #1;
        for (int i = 0; i < 2; i++) begin
            predict(i, rst, fl, iv, fv, ins, c);
            if (i == 0) begin
                o_ia = iaddr0; o_iv = ivalid0; o_fv = fetch_valid0;
                o_ins = instr0; o_c = instr_c0; o_pc = instr_pc0;
            end else begin
                o_ia = iaddr1; o_iv = ivalid1; o_fv = fetch_valid1;
                o_ins = instr1; o_c = instr_c1; o_pc = instr_pc1;
            end
            sfx = $sformatf("%0d", i);
            check({"ivalid", sfx}, 32'(o_iv), 32'(iv));
            check({"fetch_valid", sfx}, 32'(o_fv), 32'(fv));
            if (!rst) begin
                check({"iaddr", sfx}, o_ia, m_fa[i]);
                check({"instr_pc", sfx}, o_pc, m_pc[i]);
                check({"instr", sfx}, o_ins, ins);
                check({"instr_c", sfx}, 32'(o_c), 32'(c));
            end
            last_fv[i] = o_fv;
            last_iv[i] = o_iv;
            if (o_fv && dr && !rst) begin
                if (i == 0) log0.push_back({o_pc, o_ins, o_c});
                else        log1.push_back({o_pc, o_ins, o_c});
            end
            np[i] = m_pc[i];
            nf[i] = m_fa[i];
            if (rst) begin
                np[i] = (i == 0) ? (RPC0 & ~32'h1) : (RPC1 & ~32'h3);
                nf[i] = ((i == 0) ? RPC0 : RPC1) & ~32'h3;
            end else if (fl) begin
                np[i] = fpc & ((i == 0) ? ~32'h1 : ~32'h3);
                nf[i] = fpc & ~32'h3;
            end else begin
                if (iv && ir) nf[i] = m_fa[i] + 32'd4;
                if (fv && dr) np[i] = m_pc[i] + (c ? 32'd2 : 32'd4);
            end
        end
        @(posedge clock);
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = np[i];
            m_fa[i] = nf[i];
        end
    endtask

    task automatic run(input int n, input int ir_pct, input int dr_pct);
        for (int k = 0; k < n; k++)
            step(1'b0, 1'b0, 32'h0, $urandom_range(99) < ir_pct, $urandom_range(99) < dr_pct);
    endtask

    task automatic check_xfer(input string tag, input int i, input int k,
                              input logic [31:0] pc, input logic [31:0] ins, input logic c);
        xfer_t e;
        e = '0;
        if (i == 0 && k < log0.size()) e = log0[k];
        else if (i == 1 && k < log1.size()) e = log1[k];
        check({tag, "_pc"}, e.pc, pc);
        check({tag, "_instr"}, e.ins, ins);
        check({tag, "_c"}, 32'(e.c), 32'(c));
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
    endtask

    initial begin
        logic rst, fl;
        reset = 1'b1; flush = 1'b0; flush_pc = 32'h0; iready = 1'b0; decode_ready = 1'b0;
        for (int j = 0; j < 256; j++) mem[j] = 32'h0000_0013;
        m_pc[0] = 32'h0; m_pc[1] = 32'h0; m_fa[0] = 32'h0; m_fa[1] = 32'h0;

        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h8000_0200, 1'b1, 1'b1);

        // aligned stream straight out of reset
        clear_logs();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("aligned_fv_cycle0", 32'(last_fv[0]), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("aligned_fv_cycle1", 32'(last_fv[0]), 32'd1);
        run(6, 100, 100);
        check("aligned_count", 32'(log0.size()), 32'd7);
        check_xfer("aligned0", 0, 0, 32'h8000_0000, 32'h13, 1'b0);
        check_xfer("aligned1", 0, 1, 32'h8000_0004, 32'h13, 1'b0);
        check_xfer("aligned_nc0", 1, 0, 32'h8000_0000, 32'h13, 1'b0);

        // compressed pair in one word
        mem[0] = 32'h0001_4501;
        step(1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
        clear_logs();
        run(6, 100, 100);
        check_xfer("cpair0", 0, 0, 32'h8000_0000, 32'h0000_4501, 1'b1);
        check_xfer("cpair1", 0, 1, 32'h8000_0002, 32'h0000_0001, 1'b1);
        check_xfer("cpair2", 0, 2, 32'h8000_0004, 32'h0000_0013, 1'b0);
        check_xfer("nc_word0", 1, 0, 32'h8000_0000, 32'h0001_4501, 1'b0);
        check_xfer("nc_word1", 1, 1, 32'h8000_0004, 32'h0000_0013, 1'b0);

        // unaligned 32-bit instruction spanning two words
        mem[0] = 32'h0013_4501;
        mem[1] = 32'hABCD_0000;
        step(1'b0, 1'b1, 32'h8000_0002, 1'b1, 1'b1);
        clear_logs();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("unal_fv_a", 32'(last_fv[0]), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("unal_fv_b", 32'(last_fv[0]), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("unal_fv_c", 32'(last_fv[0]), 32'd1);
        run(4, 100, 100);
        check_xfer("unal0", 0, 0, 32'h8000_0002, 32'h0000_0013, 1'b0);
        check_xfer("unal1", 0, 1, 32'h8000_0006, 32'h0000_ABCD, 1'b1);
        check_xfer("unal2", 0, 2, 32'h8000_0008, 32'h0000_0013, 1'b0);
        check_xfer("nc_flush0", 1, 0, 32'h8000_0000, 32'h0013_4501, 1'b0);
        check_xfer("nc_flush1", 1, 1, 32'h8000_0004, 32'hABCD_0000, 1'b0);

        // decode backpressure with a stalling bus
        for (int j = 0; j < 256; j++) mem[j] = $urandom;
        mem[64] = 32'h0000_0013;
        mem[65] = 32'h00A0_0093;
        step(1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b0);
        run(16, 75, 0);
        check("bp_full_ivalid0", 32'(last_iv[0]), 32'd0);
        check("bp_full_ivalid1", 32'(last_iv[1]), 32'd0);
        check("bp_fv0", 32'(last_fv[0]), 32'd1);
        clear_logs();
        run(40, 60, 100);
        check("bp_first_pc", (log0.size() > 0) ? log0[0].pc : 32'h0, 32'h8000_0000);
        check("bp_drained", 32'(log0.size() >= 4), 32'd1);

        // flush colliding with an accepted word and decode_ready
        run(4, 100, 100);
        step(1'b0, 1'b1, 32'h8000_0100, 1'b1, 1'b1);
        check("flush_fv0", 32'(last_fv[0]), 32'd0);
        check("flush_iv0", 32'(last_iv[0]), 32'd0);
        clear_logs();
        run(4, 100, 100);
        check_xfer("flush_new0", 0, 0, 32'h8000_0100, 32'h0000_0013, 1'b0);
        check_xfer("flush_new1", 0, 1, 32'h8000_0104, 32'h00A0_0093, 1'b0);

        // random traffic with flushes and occasional resets
        for (int k = 0; k < 1500; k++) begin
            rst = ($urandom_range(199) == 0);
            fl  = ($urandom_range(24) == 0);
            if (rst || fl) begin
                for (int j = 0; j < 256; j++) mem[j] = $urandom;
            end
            step(rst, fl, 32'h8000_0000 | ($urandom & 32'h0000_03FF),
                 $urandom_range(99) < 70, $urandom_range(99) < 70);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
